// File: rtl/cpu_pkg.sv
// Shared datapath constants and register-select types.
// Used by the register writeback slice and its decoder.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int NREGS  = 16;
    localparam int SEL_W  = $clog2(NREGS);
    localparam int IR_W   = 32;

    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    localparam int C_W = 19;

    typedef logic [SEL_W-1:0] reg_sel_t;
    typedef logic [NREGS-1:0] reg_onehot_t;

    function automatic logic [DATA_W-1:0] sign_ext_c(
        input logic [IR_W-1:0] ir
    );
        return {{(DATA_W-C_W){ir[C_W-1]}}, ir[C_W-1:0]};
    endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Register index to one-hot strobe decoder with enable.
// All-zero output when disabled.
module reg_sel_decoder
    import cpu_pkg::*;
(
    input  reg_sel_t    sel,
    input  logic        en,
    output reg_onehot_t onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_select_writeback.sv
// General register bank R0-R15 with IR field select and bus writeback.
// Build option: REG_R0_BA_ZERO_EN makes R0 read as zero on baout.
module reg_select_writeback
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic [IR_W-1:0]   ir,
    input  logic              gra,
    input  logic              grb,
    input  logic              grc,
    input  logic              rin,
    input  logic              rout,
    input  logic              baout,
    input  logic [DATA_W-1:0] bus_mux_out,
    output reg_onehot_t       r_in,
    output reg_onehot_t       r_out,
    output logic [DATA_W-1:0] reg_data,
    output logic [DATA_W-1:0] c_sign_ext,
    output logic              sel_err
);

    logic [DATA_W-1:0] regs [NREGS];

    reg_sel_t    ra;
    reg_sel_t    rb;
    reg_sel_t    rc;
    reg_sel_t    sel;
    logic        any_gr;
    logic        wr_en;
    logic        rd_en;
    logic        multi_gr;
    reg_onehot_t wr_onehot;
    logic        unused_ir;

    assign ra = ir[RA_MSB:RA_LSB];
    assign rb = ir[RB_MSB:RB_LSB];
    assign rc = ir[RC_MSB:RC_LSB];

    assign unused_ir = ^ir[IR_W-1:RA_MSB+1];

    assign any_gr   = gra | grb | grc;
    assign multi_gr = (gra & grb) | (gra & grc) | (grb & grc);
    assign wr_en    = rin & any_gr;
    assign rd_en    = (rout | baout) & any_gr;

    always_comb begin
        sel = '0;
        if (gra) begin
            sel = ra;
        end else if (grb) begin
            sel = rb;
        end else if (grc) begin
            sel = rc;
        end
    end

    reg_sel_decoder u_rd_dec (
        .sel    (sel),
        .en     (rd_en),
        .onehot (r_out)
    );

    reg_sel_decoder u_wr_dec (
        .sel    (sel),
        .en     (wr_en),
        .onehot (wr_onehot)
    );

    // Reads see the pre-write value; no write-to-read bypass.
    always_comb begin
        reg_data = '0;
        if (rd_en) begin
            reg_data = regs[sel];
`ifdef REG_R0_BA_ZERO_EN
            if (baout && sel == '0) begin
                reg_data = '0;
            end
`endif
        end
    end

    assign c_sign_ext = sign_ext_c(ir);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            r_in    <= '0;
            sel_err <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[sel] <= bus_mux_out;
            end
            r_in <= wr_onehot;
            if (multi_gr || (rin && rout)) begin
                sel_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_select_writeback.sv
// Directed-vector bench for reg_select_writeback.
// Expected R0/baout result depends on REG_R0_BA_ZERO_EN.
module tb_reg_select_writeback;

    logic        clk;
    logic        clr_n;
    logic [31:0] ir;
    logic        gra;
    logic        grb;
    logic        grc;
    logic        rin;
    logic        rout;
    logic        baout;
    logic [31:0] bus_mux_out;
    logic [15:0] r_in;
    logic [15:0] r_out;
    logic [31:0] reg_data;
    logic [31:0] c_sign_ext;
    logic        sel_err;

    int n_vec;
    int n_err;

    reg_select_writeback dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .ir          (ir),
        .gra         (gra),
        .grb         (grb),
        .grc         (grc),
        .rin         (rin),
        .rout        (rout),
        .baout       (baout),
        .bus_mux_out (bus_mux_out),
        .r_in        (r_in),
        .r_out       (r_out),
        .reg_data    (reg_data),
        .c_sign_ext  (c_sign_ext),
        .sel_err     (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        gra = 0; grb = 0; grc = 0;
        rin = 0; rout = 0; baout = 0;
    endtask

    function automatic logic [31:0] mk_ir(
        input int ra, input int rb, input int rc
    );
        logic [31:0] v;
        v = '0;
        v[26:23] = ra[3:0];
        v[22:19] = rb[3:0];
        v[18:15] = rc[3:0];
        return v;
    endfunction

    logic [31:0] exp_ba;

    initial begin
        n_vec = 0;
        n_err = 0;
        clr_n = 0;
        ir = '0;
        bus_mux_out = '0;
        idle();
        #3;
        chk("rst_r_in", {16'h0, r_in}, 32'h0);
        chk("rst_r_out", {16'h0, r_out}, 32'h0);
        chk("rst_err", {31'h0, sel_err}, 32'h0);
        chk("rst_data", reg_data, 32'h0);
        tick();
        clr_n = 1;

        // write R3 then read it back
        ir = mk_ir(3, 0, 0);
        gra = 1; rin = 1; bus_mux_out = 32'h12345678;
        tick();
        chk("wr_r_in", {16'h0, r_in}, 32'h0000_0008);
        rin = 0; rout = 1;
        #1;
        chk("rd_r_out", {16'h0, r_out}, 32'h0000_0008);
        chk("rd_data", reg_data, 32'h12345678);
        tick();
        chk("r_in_pulse", {16'h0, r_in}, 32'h0);
        chk("no_err", {31'h0, sel_err}, 32'h0);
        idle();
        rout = 1;
        #1;
        chk("no_gr_r_out", {16'h0, r_out}, 32'h0);
        chk("no_gr_data", reg_data, 32'h0);

        // same-cycle rin and rout on Rb=7
        idle();
        ir = mk_ir(0, 7, 0);
        grb = 1; rin = 1; bus_mux_out = 32'hA;
        tick();
        rout = 1; bus_mux_out = 32'hB;
        #1;
        chk("rw_old", reg_data, 32'hA);
        chk("rw_err_pre", {31'h0, sel_err}, 32'h0);
        tick();
        chk("rw_err", {31'h0, sel_err}, 32'h1);
        rin = 0;
        #1;
        chk("rw_new", reg_data, 32'hB);

        // async reset after writing R5
        idle();
        ir = mk_ir(5, 0, 0);
        gra = 1; rin = 1; bus_mux_out = 32'hDEADBEEF;
        tick();
        rin = 0; rout = 1;
        #1;
        chk("r5_data", reg_data, 32'hDEADBEEF);
        clr_n = 0;
        #1;
        chk("arst_data", reg_data, 32'h0);
        chk("arst_r_in", {16'h0, r_in}, 32'h0);
        chk("arst_err", {31'h0, sel_err}, 32'h0);
        ir = mk_ir(0, 7, 0);
        gra = 0; grb = 1;
        #1;
        chk("arst_r7", reg_data, 32'h0);
        tick();
        clr_n = 1;

        // gra and grc together
        idle();
        ir = mk_ir(2, 0, 9);
        gra = 1; grc = 1; rin = 1; bus_mux_out = 32'h55;
        tick();
        chk("multi_err", {31'h0, sel_err}, 32'h1);
        idle();
        gra = 1; rout = 1;
        #1;
        chk("multi_r2", reg_data, 32'h55);
        gra = 0; grc = 1;
        #1;
        chk("multi_r9_oh", {16'h0, r_out}, 32'h0000_0200);
        chk("multi_r9", reg_data, 32'h0);
        tick();
        tick();
        chk("err_sticky", {31'h0, sel_err}, 32'h1);
        clr_n = 0;
        #1;
        chk("err_clr", {31'h0, sel_err}, 32'h0);
        tick();
        clr_n = 1;

        // constant sign extension
        idle();
        ir = 32'h0004_0000;
        #1;
        chk("sext_neg", c_sign_ext, 32'hFFFC0000);
        ir = 32'h0003_FFFF;
        #1;
        chk("sext_pos", c_sign_ext, 32'h0003FFFF);

        // R0 under baout and rout
        ir = mk_ir(0, 0, 0);
        gra = 1; rin = 1; bus_mux_out = 32'h100;
        tick();
        rin = 0; baout = 1;
        #1;
`ifdef REG_R0_BA_ZERO_EN
        exp_ba = 32'h0;
`else
        exp_ba = 32'h100;
`endif
        chk("r0_ba", reg_data, exp_ba);
        chk("r0_ba_oh", {16'h0, r_out}, 32'h1);
        baout = 0; rout = 1;
        #1;
        chk("r0_rout", reg_data, 32'h100);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
